// File: rtl/lcd_sequencer.sv
// lcd_sequencer: streams a 16-entry command/character ROM onto an HD44780 bus.
// Each ROM word (bit 8 = RS, bits 7:0 = byte) becomes one write cycle:
// LOAD (latch word), 2 setup cycles, an E pulse, then a command-dependent wait.
// Optional feature macro: LCD_SEQ_INIT_EN. When defined, a power-up delay and
// the four-command controller init (0x38, 0x0C, 0x01, 0x06) run before the ROM
// stream. When undefined, the block starts streaming ROM address 0 right after reset.
module lcd_sequencer #(
   parameter int E_PULSE_CYCLES    = 12,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000,
   parameter int POWERUP_CYCLES    = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] rom_addr,
   input  logic [8:0] rom_data,
   output logic       busy,
   output logic       done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_db
);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // One shared counter covers the longest of the three waits, with a spare bit
   // so a terminal count can never wrap.
   localparam int MAX_AB = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int MAX_W  = (MAX_AB > POWERUP_CYCLES) ? MAX_AB : POWERUP_CYCLES;
   localparam int CW     = $clog2(MAX_W) + 1;

   localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYCLES - 1);
   localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(1);

`ifdef LCD_SEQ_INIT_EN
   localparam state_t RESET_STATE = ST_POWERUP;
   localparam logic   INIT_EN     = 1'b1;
`else
   localparam state_t RESET_STATE = ST_LOAD;
   localparam logic   INIT_EN     = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [3:0]    addr_q, addr_d;
   logic          rs_q, rs_d;
   logic [7:0]    db_q, db_d;
   logic          e_q;
   logic          init_phase_q, init_phase_d;
   logic [1:0]    init_idx_q, init_idx_d;
   logic [7:0]    init_byte;
   logic [8:0]    word;

   // Init command table, indexed by the init step.
   always_comb begin
      init_byte = 8'h06;
      case (init_idx_q)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   end

   // Next-state logic: sequencing, word latching and wait selection.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      wait_d       = wait_q;
      addr_d       = addr_q;
      rs_d         = rs_q;
      db_d         = db_q;
      init_phase_d = init_phase_q;
      init_idx_d   = init_idx_q;
      word         = init_phase_q ? {1'b0, init_byte} : rom_data;
      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == PWR_LAST) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            rs_d    = word[8];
            db_d    = word[7:0];
            wait_d  = (!word[8] && (word[7:0] == 8'h01 || word[7:0] == 8'h02)) ? CLEAR_LAST : CMD_LAST;
            state_d = ST_SETUP;
            cnt_d   = '0;
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_PULSE;
               cnt_d   = '0;
            end
         end
         ST_PULSE: begin
            if (cnt_q == E_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == wait_q) begin
               cnt_d   = '0;
               state_d = ST_LOAD;
               if (init_phase_q) begin
                  if (init_idx_q == 2'd3) begin
                     init_phase_d = 1'b0;
                  end else begin
                     init_idx_d = init_idx_q + 2'd1;
                  end
               end else if (addr_q == 4'hF) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d = addr_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            cnt_d = '0;
            if (start) begin
               addr_d  = 4'd0;
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = RESET_STATE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and bus registers; reset aborts any write immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RESET_STATE;
         cnt_q        <= '0;
         wait_q       <= CMD_LAST;
         addr_q       <= 4'd0;
         rs_q         <= 1'b0;
         db_q         <= 8'h00;
         e_q          <= 1'b0;
         init_phase_q <= INIT_EN;
         init_idx_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wait_q       <= wait_d;
         addr_q       <= addr_d;
         rs_q         <= rs_d;
         db_q         <= db_d;
         e_q          <= (state_d == ST_PULSE);
         init_phase_q <= init_phase_d;
         init_idx_q   <= init_idx_d;
      end
   end

   assign rom_addr = addr_q;
   assign busy     = (state_q != ST_DONE);
   assign done     = (state_q == ST_DONE);
   assign lcd_e    = e_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_db   = db_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: the stimulus pushes the expected writes,
// a monitor pops one per E pulse and checks data, pulse width, gaps and bus hold.
module tb_lcd_sequencer;

   localparam int EP = 2;
   localparam int CW_ = 4;
   localparam int CL = 10;
   localparam int PW = 20;
`ifdef LCD_SEQ_INIT_EN
   localparam int FIRST_RISE = 23;
`else
   localparam int FIRST_RISE = 3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] rom_addr;
   logic [8:0] rom_data;
   logic       busy, done, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_db;

   typedef struct packed {
      logic       rs;
      logic [7:0] db;
      int         w;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   lcd_sequencer #(
      .E_PULSE_CYCLES   (EP),
      .CMD_WAIT_CYCLES  (CW_),
      .CLEAR_WAIT_CYCLES(CL),
      .POWERUP_CYCLES   (PW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .busy    (busy),
      .done    (done),
      .lcd_e   (lcd_e),
      .lcd_rs  (lcd_rs),
      .lcd_rw  (lcd_rw),
      .lcd_db  (lcd_db)
   );

   always #5 clk = ~clk;

   // Message ROM: line 1 "Hello", line 2 "World!", home, user char 1, '.'
   function automatic logic [8:0] rom_word(input logic [3:0] a);
      case (a)
         4'd0:    return 9'h080;
         4'd1:    return 9'h148;
         4'd2:    return 9'h165;
         4'd3:    return 9'h16C;
         4'd4:    return 9'h16C;
         4'd5:    return 9'h16F;
         4'd6:    return 9'h0C0;
         4'd7:    return 9'h157;
         4'd8:    return 9'h16F;
         4'd9:    return 9'h172;
         4'd10:   return 9'h16C;
         4'd11:   return 9'h164;
         4'd12:   return 9'h121;
         4'd13:   return 9'h002;
         4'd14:   return 9'h101;
         default: return 9'h12E;
      endcase
   endfunction

   // Hand-derived wait after each ROM word: only 0x002 with RS=0 is a long wait
   // (0x101 is a character, so it gets the ordinary wait).
   function automatic int rom_wait(input logic [3:0] a);
      return (a == 4'd13) ? CL : CW_;
   endfunction

   assign rom_data = rom_word(rom_addr);

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic push_w(input logic rs, input logic [7:0] db, input int w);
      exp_t e;
      e.rs = rs;
      e.db = db;
      e.w  = w;
      q.push_back(e);
   endtask

   task automatic push_stream(input bit with_init);
      logic [8:0] wd;
`ifdef LCD_SEQ_INIT_EN
      if (with_init) begin
         push_w(1'b0, 8'h38, CW_);
         push_w(1'b0, 8'h0C, CW_);
         push_w(1'b0, 8'h01, CL);
         push_w(1'b0, 8'h06, CW_);
      end
`endif
      for (int i = 0; i < 16; i++) begin
         wd = rom_word(4'(i));
         push_w(wd[8], wd[7:0], rom_wait(4'(i)));
      end
   endtask

   // ---------------- monitor ----------------
   int         cyc = 0, rise_cyc = 0, fall_cyc = 0, last_wait = 0, stable = 0;
   bit         in_pulse = 0, have_fall = 0, armed = 0, e_prev = 0, done_prev = 0;
   logic [8:0] bus_prev = 9'h000;

   initial begin : monitor
      exp_t ex;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            in_pulse = 0; have_fall = 0; armed = 0; e_prev = 0; done_prev = 0;
            bus_prev = {lcd_rs, lcd_db};
            stable = 0;
         end else begin
            if (lcd_rw !== 1'b0) chk("lcd_rw", int'(lcd_rw), 0);
            if ({lcd_rs, lcd_db} !== bus_prev) begin
               if (armed) chk("bus_change_after_wait", cyc - fall_cyc, last_wait + 1);
               else if (in_pulse) chk("bus_change_in_pulse", 1, 0);
               armed  = 0;
               stable = 1;
            end else begin
               stable++;
            end
            bus_prev = {lcd_rs, lcd_db};
            if (lcd_e && !e_prev) begin
               chk("bus_setup_hold", (stable >= 3) ? 1 : 0, 1);
               if (q.size() == 0) begin
                  chk("unexpected_write", 1, 0);
               end else begin
                  ex = q.pop_front();
                  $display("write rs=%0d db=0x%02h (expect rs=%0d db=0x%02h) t=%0t",
                           lcd_rs, lcd_db, ex.rs, ex.db, $time);
                  chk("write_rs", int'(lcd_rs), int'(ex.rs));
                  chk("write_db", int'(lcd_db), int'(ex.db));
                  if (have_fall) chk("gap_fall_to_rise", cyc - fall_cyc, last_wait + 3);
                  last_wait = ex.w;
               end
               rise_cyc = cyc; in_pulse = 1; have_fall = 0; armed = 0;
            end
            if (!lcd_e && e_prev) begin
               chk("e_pulse_width", cyc - rise_cyc, EP);
               fall_cyc = cyc; have_fall = 1; armed = 1; in_pulse = 0;
            end
            if (done && !done_prev) begin
               if (have_fall) chk("done_after_last_wait", cyc - fall_cyc, last_wait);
               have_fall = 0; armed = 0;
            end
            e_prev    = lcd_e;
            done_prev = done;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic release_and_first();
      int n;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (n <= 100) begin
         @(negedge clk);
         n++;
         if (lcd_e) break;
      end
      chk("first_e_rise_cycle", n, FIRST_RISE);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("wait_done_timeout", 1, 0);
   endtask

   task automatic wait_cond(input bit need_e, input logic [3:0] a, input string name);
      int n = 0;
      while (!((!need_e || lcd_e) && rom_addr == a) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk(name, 1, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_rom_addr"}, int'(rom_addr), 15);
      chk({tag, "_queue_empty"}, q.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_lcd_e", int'(lcd_e), 0);
      chk("rst_lcd_rs", int'(lcd_rs), 0);
      chk("rst_lcd_rw", int'(lcd_rw), 0);
      chk("rst_lcd_db", int'(lcd_db), 0);

      // Power-up / init / first stream
      push_stream(1'b1);
      release_and_first();
      wait_done();
      @(negedge clk);
      end_checks("stream1");

      // Replay from DONE, plus an ignored start mid-stream
      push_stream(1'b0);
      pulse_start();
      chk("replay_busy", int'(busy), 1);
      chk("replay_done", int'(done), 0);
      wait_cond(1'b0, 4'd5, "wait_addr5_timeout");
      pulse_start();
      wait_done();
      @(negedge clk);
      end_checks("replay");

      // Reset while E is high on address 3
      push_stream(1'b0);
      pulse_start();
      wait_cond(1'b1, 4'd3, "wait_e_addr3_timeout");
      #1 reset = 1'b1;
      #1;
      chk("abort_lcd_e", int'(lcd_e), 0);
      chk("abort_lcd_db", int'(lcd_db), 0);
      chk("abort_rom_addr", int'(rom_addr), 0);
      q.delete();
      repeat (2) @(negedge clk);
      push_stream(1'b1);
      release_and_first();
      wait_done();
      @(negedge clk);
      end_checks("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
